// File: rtl/jt49_mix_seq.sv
// PSG mixer: gates tone/noise per channel, maps level through a shared log
// volume ROM one channel per step, and emits the summed sample every fourth step.
module jt49_mix_seq #(
  parameter int SUMW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic            tone_a,
  input  logic            tone_b,
  input  logic            tone_c,
  input  logic            noise,
  input  logic [5:0]      mixer_n,
  input  logic [4:0]      amp_a,
  input  logic [4:0]      amp_b,
  input  logic [4:0]      amp_c,
  input  logic [4:0]      envelope,
  output logic [7:0]      vol_a,
  output logic [7:0]      vol_b,
  output logic [7:0]      vol_c,
  output logic [SUMW-1:0] sound,
  output logic            sample
);

  typedef enum logic [1:0] {ST_A, ST_B, ST_C, ST_SUM} state_t;

  state_t          state, state_nx;
  logic [SUMW-1:0] acc;
  logic            tone_sel, tone_en_n, noise_en_n, gate;
  logic [4:0]      amp_sel, level, lin;
  logic [7:0]      vol_lin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_A;
    else     state <= state_nx;
  end

  // Channel operand mux: only the channel owning this step is looked at
  always_comb begin
    state_nx   = state;
    tone_sel   = 1'b0;
    tone_en_n  = 1'b1;
    noise_en_n = 1'b1;
    amp_sel    = 5'd0;
    case (state)
      ST_A: begin
        tone_sel = tone_a; tone_en_n = mixer_n[0]; noise_en_n = mixer_n[3]; amp_sel = amp_a;
        if (cen) state_nx = ST_B;
      end
      ST_B: begin
        tone_sel = tone_b; tone_en_n = mixer_n[1]; noise_en_n = mixer_n[4]; amp_sel = amp_b;
        if (cen) state_nx = ST_C;
      end
      ST_C: begin
        tone_sel = tone_c; tone_en_n = mixer_n[2]; noise_en_n = mixer_n[5]; amp_sel = amp_c;
        if (cen) state_nx = ST_SUM;
      end
      default: begin
        if (cen) state_nx = ST_A;
      end
    endcase
  end

  assign gate  = (tone_sel | tone_en_n) & (noise | noise_en_n);
  assign level = amp_sel[4] ? envelope : {amp_sel[3:0], 1'b1};
  assign lin   = gate ? level : 5'd0;

  // 1.5 dB per step, full scale 255
  always_comb begin
    vol_lin = 8'd0;
    case (lin)
      5'd0:  vol_lin = 8'd0;    5'd1:  vol_lin = 8'd1;
      5'd2:  vol_lin = 8'd2;    5'd3:  vol_lin = 8'd2;
      5'd4:  vol_lin = 8'd2;    5'd5:  vol_lin = 8'd3;
      5'd6:  vol_lin = 8'd3;    5'd7:  vol_lin = 8'd4;
      5'd8:  vol_lin = 8'd5;    5'd9:  vol_lin = 8'd6;
      5'd10: vol_lin = 8'd7;    5'd11: vol_lin = 8'd8;
      5'd12: vol_lin = 8'd10;   5'd13: vol_lin = 8'd11;
      5'd14: vol_lin = 8'd14;   5'd15: vol_lin = 8'd16;
      5'd16: vol_lin = 8'd19;   5'd17: vol_lin = 8'd23;
      5'd18: vol_lin = 8'd27;   5'd19: vol_lin = 8'd32;
      5'd20: vol_lin = 8'd38;   5'd21: vol_lin = 8'd45;
      5'd22: vol_lin = 8'd54;   5'd23: vol_lin = 8'd64;
      5'd24: vol_lin = 8'd76;   5'd25: vol_lin = 8'd90;
      5'd26: vol_lin = 8'd108;  5'd27: vol_lin = 8'd128;
      5'd28: vol_lin = 8'd152;  5'd29: vol_lin = 8'd181;
      5'd30: vol_lin = 8'd215;  default: vol_lin = 8'd255;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      vol_a <= 8'd0;
      vol_b <= 8'd0;
      vol_c <= 8'd0;
      sound <= '0;
    end else if (cen) begin
      case (state)
        ST_A:    begin vol_a <= vol_lin; acc <= SUMW'(vol_lin);       end
        ST_B:    begin vol_b <= vol_lin; acc <= acc + SUMW'(vol_lin); end
        ST_C:    begin vol_c <= vol_lin; acc <= acc + SUMW'(vol_lin); end
        default: sound <= acc;
      endcase
    end
  end

  // Strobe drops on the next clk regardless of cen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sample <= 1'b0;
    else     sample <= cen && (state == ST_SUM);
  end

endmodule

// File: tb/tb_jt49_mix_seq.sv
// Self-checking bench for jt49_mix_seq: vector table, directed corner cases
// and randomized stimulus against a frame-level reference model.
module tb_jt49_mix_seq;

  logic       clk = 1'b0, rst = 1'b1, cen = 1'b0;
  logic       tone_a = 0, tone_b = 0, tone_c = 0, noise = 0;
  logic [5:0] mixer_n = 6'h3F;
  logic [4:0] amp_a = 0, amp_b = 0, amp_c = 0, envelope = 0;
  logic [7:0] vol_a, vol_b, vol_c;
  logic [9:0] sound;
  logic       sample;

  int n_tests = 0, n_fail = 0;

  int step;
  int ev[3];
  int es;
  int esmp;

  jt49_mix_seq #(.SUMW(10)) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .tone_a(tone_a), .tone_b(tone_b), .tone_c(tone_c), .noise(noise),
    .mixer_n(mixer_n), .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c),
    .envelope(envelope), .vol_a(vol_a), .vol_b(vol_b), .vol_c(vol_c),
    .sound(sound), .sample(sample)
  );

  always #5 clk = ~clk;

  function automatic int ref_tbl(input int k);
    if (k == 0) return 0;
    return $rtoi(255.0 * $pow(10.0, -1.5 * real'(31 - k) / 20.0) + 0.5);
  endfunction

  function automatic int ref_vol(input int ch);
    logic [4:0] amp;
    int t, lvl, g;
    amp = (ch == 0) ? amp_a : (ch == 1) ? amp_b : amp_c;
    t   = (ch == 0) ? int'(tone_a) : (ch == 1) ? int'(tone_b) : int'(tone_c);
    g   = (t | int'(mixer_n[ch])) & (int'(noise) | int'(mixer_n[ch+3]));
    lvl = amp[4] ? int'(envelope) : int'(amp[3:0]) * 2 + 1;
    return g ? ref_tbl(lvl) : 0;
  endfunction

  task automatic model_reset();
    step = 0; es = 0; esmp = 0;
    for (int i = 0; i < 3; i++) ev[i] = 0;
  endtask

  // Each cen is one slot of a 4-slot frame: channels A,B,C then the sum slot
  task automatic model_edge();
    esmp = 0;
    if (cen) begin
      if (step < 3) ev[step] = ref_vol(step);
      else begin
        es   = ev[0] + ev[1] + ev[2];
        esmp = 1;
      end
      step = (step + 1) % 4;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".vol_a"}, int'(vol_a), ev[0]);
    chk({tag, ".vol_b"}, int'(vol_b), ev[1]);
    chk({tag, ".vol_c"}, int'(vol_c), ev[2]);
    chk({tag, ".sound"}, int'(sound), es);
    chk({tag, ".sample"}, int'(sample), esmp);
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    #1;
    if (rst) model_reset(); else model_edge();
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input logic [5:0] mx, input logic [4:0] a, input logic [4:0] b,
                               input logic [4:0] c, input logic [2:0] tn, input logic nz,
                               input logic [4:0] env);
    mixer_n = mx; amp_a = a; amp_b = b; amp_c = c;
    {tone_c, tone_b, tone_a} = tn; noise = nz; envelope = env;
  endtask

  typedef struct {
    logic [5:0] mx;
    logic [4:0] amp;
    logic       tn;
    logic       nz;
    logic [4:0] env;
    int         evol;
    int         esnd;
  } vec_t;

  vec_t vt[12];

  initial begin
    vt[0]  = '{6'h3F, 5'h0F, 1'b0, 1'b0, 5'd0,  255, 765};
    vt[1]  = '{6'h3F, 5'h00, 1'b0, 1'b0, 5'd0,  1,   3};
    vt[2]  = '{6'h00, 5'h0F, 1'b0, 1'b1, 5'd0,  0,   0};
    vt[3]  = '{6'h00, 5'h0F, 1'b1, 1'b1, 5'd0,  255, 765};
    vt[4]  = '{6'h38, 5'h0F, 1'b0, 1'b0, 5'd0,  0,   0};
    vt[5]  = '{6'h38, 5'h0F, 1'b1, 1'b0, 5'd0,  255, 765};
    vt[6]  = '{6'h07, 5'h0F, 1'b1, 1'b0, 5'd0,  0,   0};
    vt[7]  = '{6'h07, 5'h0F, 1'b0, 1'b1, 5'd0,  255, 765};
    vt[8]  = '{6'h3F, 5'h10, 1'b0, 1'b0, 5'd0,  0,   0};
    vt[9]  = '{6'h3F, 5'h10, 1'b0, 1'b0, 5'd31, 255, 765};
    vt[10] = '{6'h3F, 5'h10, 1'b0, 1'b0, 5'd16, 19,  57};
    vt[11] = '{6'h3F, 5'h08, 1'b0, 1'b0, 5'd0,  23,  69};

    // Reset held with cen toggling
    model_reset();
    applyStimulus(6'h3F, 5'h0F, 5'h0F, 5'h0F, 3'b000, 1'b0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      cen = i[0];
      cyc("reset");
    end
    rst = 1'b0;
    cen = 1'b1;
    for (int i = 0; i < 4; i++) cyc("first_frame");
    chk("first_sound", int'(sound), 765);
    chk("first_sample", int'(sample), 1);
    for (int i = 0; i < 8; i++) cyc("steady");

    // Vector table: uniform inputs on all channels, two frames each
    foreach (vt[i]) begin
      applyStimulus(vt[i].mx, vt[i].amp, vt[i].amp, vt[i].amp,
                    {3{vt[i].tn}}, vt[i].nz, vt[i].env);
      for (int k = 0; k < 8; k++) cyc("vec");
      chk("vec_vol_a", int'(vol_a), vt[i].evol);
      chk("vec_vol_c", int'(vol_c), vt[i].evol);
      chk("vec_sound", int'(sound), vt[i].esnd);
    end

    // Tone gating on A only
    applyStimulus(6'b111110, 5'h0F, 5'h00, 5'h00, 3'b000, 1'b0, 5'd0);
    for (int k = 0; k < 8; k++) cyc("tone_gate");
    chk("tone_off_sound", int'(sound), 2);
    tone_a = 1'b1;
    for (int k = 0; k < 8; k++) cyc("tone_gate");
    chk("tone_on_sound", int'(sound), 257);

    // Envelope sweep on A must follow the table monotonically
    applyStimulus(6'h3F, 5'h10, 5'h00, 5'h00, 3'b000, 1'b0, 5'd0);
    for (int e = 0; e < 32; e++) begin
      int prev;
      prev = int'(vol_a);
      envelope = 5'(e);
      for (int k = 0; k < 4; k++) cyc("env_sweep");
      chk("env_vol_a", int'(vol_a), ref_tbl(e));
      if (e > 0) chk("env_monotonic", int'(vol_a >= 8'(prev)), 1);
    end

    // cen held low mid-frame: nothing moves, no strobe
    applyStimulus(6'h3F, 5'h0F, 5'h05, 5'h0A, 3'b000, 1'b0, 5'd0);
    for (int k = 0; k < 6; k++) cyc("pre_hold");
    cen = 1'b0;
    for (int k = 0; k < 20; k++) cyc("cen_hold");
    cen = 1'b1;
    for (int k = 0; k < 8; k++) cyc("resume");

    // Asynchronous reset while in ST_B
    while (step != 1) cyc("align");
    rst = 1'b1;
    #2;
    model_reset();
    checkOutput("async_rst");
    cyc("rst_held");
    rst = 1'b0;
    applyStimulus(6'h3F, 5'h0F, 5'h0F, 5'h0F, 3'b000, 1'b0, 5'd0);
    for (int k = 0; k < 3; k++) begin
      cyc("post_rst");
      chk("no_early_sample", int'(sample), 0);
    end
    cyc("post_rst");
    chk("fourth_cen_sample", int'(sample), 1);

    // Randomized inputs and cen against the model
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    3'($urandom), 1'($urandom), 5'($urandom));
      cen = ($urandom_range(0, 3) != 0);
      cyc("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
